bank_cmd_sequencer: RTL and testbench

// Per-bank sequencer between the frontend request path and the command scheduler/PHY.

---
 rtl/bank_cmd_sequencer_if.sv | 79 +++++++
 rtl/bank_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bank_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_cmd_sequencer_if.sv
// Shared types for the bank command path, and the request/command/completion
// bundle between the frontend, one bank sequencer and the scheduler/PHY.
package bank_cmd_pkg;

    localparam int ROW_BITS = 14;
    localparam int COL_BITS = 14;

    typedef logic [4:0] req_id_t;
    typedef logic [1:0] core_num_t;
    typedef logic [1:0] data_type_t;

    typedef enum logic [0:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_type_t;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVE    = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4,
        CMD_RDA       = 3'd5,
        CMD_WRA       = 3'd6,
        CMD_REFRESH   = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        BL_OTF  = 2'd0,
        BL_4    = 2'd1,
        BL_8    = 2'd2,
        BL_RSVD = 2'd3
    } burst_length_t;

    typedef struct packed {
        op_type_t              op_type;
        data_type_t            data_type;
        logic [ROW_BITS-1:0]   row_addr;
        logic [COL_BITS-1:0]   col_addr;
    } frontend_command_t;

    typedef struct packed {
        cmd_t                  cmd;
        burst_length_t         burst_length;
        logic [13:0]           row_addr;
        logic [13:0]           col_addr;
        logic [2:0]            bank_addr;
    } bank_command_t;

endpackage

interface bank_cmd_sequencer_if;
    import bank_cmd_pkg::*;

    logic              req_valid;
    logic              req_ready;
    frontend_command_t req_cmd;
    req_id_t           req_id;
    core_num_t         req_core;

    logic              cmd_valid;
    logic              cmd_ready;
    bank_command_t     cmd_o;

    logic              done_valid;
    req_id_t           done_req_id;
    core_num_t         done_core;

    modport slave (
        input  req_valid, req_cmd, req_id, req_core, cmd_ready,
        output req_ready, cmd_valid, cmd_o, done_valid, done_req_id, done_core
    );

    modport master (
        output req_valid, req_cmd, req_id, req_core, cmd_ready,
        input  req_ready, cmd_valid, cmd_o, done_valid, done_req_id, done_core
    );

endinterface

// File: rtl/bank_cmd_sequencer.sv
// Open-page bank sequencer: expands one frontend request into ACT/RD/WR/PRE
// beats while holding off each beat until its DRAM timing counters expire.
module bank_cmd_sequencer
    import bank_cmd_pkg::*;
#(
    parameter logic [2:0]    BANK_ID = 3'd0,
    parameter int            T_RCD   = 3,
    parameter int            T_RP    = 3,
    parameter int            T_RAS   = 8,
    parameter int            T_CCD   = 4,
    parameter int            T_WR    = 4,
    parameter burst_length_t BL      = BL_8
) (
    input  logic                clk,
    input  logic                rst,
    bank_cmd_sequencer_if.slave bus,
    input  logic                close_req,
    output logic                closed,
    output logic [ROW_BITS-1:0] open_row
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);

    typedef enum logic [2:0] {
        S_CLOSED    = 3'd0,
        S_ISSUE_ACT = 3'd1,
        S_ISSUE_RW  = 3'd2,
        S_OPEN      = 3'd3,
        S_ISSUE_PRE = 3'd4
    } state_t;

    state_t              state_q, state_d, fire_state;
    logic                pending_q;
    frontend_command_t   req_q;
    req_id_t             id_q, done_id_q;
    core_num_t           core_q, done_core_q;
    logic                done_valid_q;
    logic [ROW_BITS-1:0] open_row_q;
    logic [CNT_W-1:0]    trcd_q, trp_q, tras_q, tccd_q, twr_q;

    logic                accept, row_hit, issue_ok, issue_valid, cmd_fire;
    logic                fire_act, fire_rw, fire_pre;
    bank_command_t       beat;

    // data_type rides along with the request but never steers sequencing.
    logic unused_data_type;
    assign unused_data_type = ^req_q.data_type;

    function automatic logic [CNT_W-1:0] count_down(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign bus.req_ready = (state_q == S_CLOSED || state_q == S_OPEN) &&
                           !pending_q && !close_req && !rst;
    assign accept   = bus.req_valid && bus.req_ready;
    assign row_hit  = bus.req_cmd.row_addr == open_row_q;
    assign cmd_fire = issue_valid && bus.cmd_ready;
    assign fire_act = cmd_fire && state_q == S_ISSUE_ACT;
    assign fire_rw  = cmd_fire && state_q == S_ISSUE_RW;
    assign fire_pre = cmd_fire && state_q == S_ISSUE_PRE;

    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        fire_state        = state_q;
        issue_ok          = 1'b0;
        beat              = '0;
        beat.burst_length = BL;
        beat.bank_addr    = BANK_ID;
        case (state_q)
            S_CLOSED: begin
                if (accept || pending_q) state_d = S_ISSUE_ACT;
            end
            S_OPEN: begin
                if (accept)         state_d = row_hit ? S_ISSUE_RW : S_ISSUE_PRE;
                else if (close_req) state_d = S_ISSUE_PRE;
            end
            S_ISSUE_ACT: begin
                issue_ok      = (trp_q == '0);
                beat.cmd      = CMD_ACTIVE;
                beat.row_addr = req_q.row_addr;
                fire_state    = S_ISSUE_RW;
            end
            S_ISSUE_RW: begin
                issue_ok      = (trcd_q == '0) && (tccd_q == '0);
                beat.cmd      = (req_q.op_type == OP_READ) ? CMD_READ : CMD_WRITE;
                beat.col_addr = req_q.col_addr;
                fire_state    = S_OPEN;
            end
            S_ISSUE_PRE: begin
                issue_ok   = (tras_q == '0) && (twr_q == '0);
                beat.cmd   = CMD_PRECHARGE;
                fire_state = S_CLOSED;
            end
            default: state_d = S_CLOSED;
        endcase
        issue_valid = issue_ok && !rst;
        if (issue_valid && bus.cmd_ready) state_d = fire_state;
    end

    // The beat is a function of registered state only, so it stays stable
    // across backpressure without a separate output register.
    assign bus.cmd_valid = issue_valid;
    assign bus.cmd_o     = issue_valid ? beat : '0;

    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLOSED;
            pending_q    <= 1'b0;
            req_q        <= '0;
            id_q         <= '0;
            core_q       <= '0;
            open_row_q   <= '0;
            trcd_q       <= '0;
            trp_q        <= '0;
            tras_q       <= '0;
            tccd_q       <= '0;
            twr_q        <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_core_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pending_q <= 1'b1;
                req_q     <= bus.req_cmd;
                id_q      <= bus.req_id;
                core_q    <= bus.req_core;
            end else if (fire_rw) begin
                pending_q <= 1'b0;
            end
            if (fire_act) open_row_q <= req_q.row_addr;

            trcd_q <= fire_act ? LD_RCD : count_down(trcd_q);
            tras_q <= fire_act ? LD_RAS : count_down(tras_q);
            tccd_q <= fire_rw  ? LD_CCD : count_down(tccd_q);
            twr_q  <= (fire_rw && req_q.op_type == OP_WRITE) ? LD_WR : count_down(twr_q);
            trp_q  <= fire_pre ? LD_RP  : count_down(trp_q);

            done_valid_q <= fire_rw;
            if (fire_rw) begin
                done_id_q   <= id_q;
                done_core_q <= core_q;
            end
        end
    end

    assign bus.done_valid  = done_valid_q;
    assign bus.done_req_id = done_id_q;
    assign bus.done_core   = done_core_q;
    assign closed          = (state_q == S_CLOSED) && !pending_q;
    assign open_row        = open_row_q;

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Directed bench for bank_cmd_sequencer: cold access, row hit, row miss,
// backpressure, close requests and reset in flight, all at default timings.
module tb_bank_cmd_sequencer;
    import bank_cmd_pkg::*;

    localparam logic [2:0] BANK = 3'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        close_req;
    logic        closed;
    logic [13:0] open_row;

    bank_cmd_sequencer_if bus();

    bank_cmd_sequencer #(.BANK_ID(BANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .close_req (close_req),
        .closed    (closed),
        .open_row  (open_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        bank_command_t c;
    } cmd_ev_t;

    typedef struct {
        int        cyc;
        req_id_t   id;
        core_num_t core;
    } done_ev_t;

    cmd_ev_t  cmd_log[$];
    done_ev_t done_log[$];
    cmd_ev_t  mon_c;
    done_ev_t mon_d;

    // Handshakes are recorded mid-cycle, tagged with the cycle they occur in.
    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) begin
            mon_c.cyc = cyc;
            mon_c.c   = bus.cmd_o;
            cmd_log.push_back(mon_c);
        end
        if (bus.done_valid) begin
            mon_d.cyc  = cyc;
            mon_d.id   = bus.done_req_id;
            mon_d.core = bus.done_core;
            done_log.push_back(mon_d);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bank_command_t mk(input cmd_t c, input logic [13:0] row, input logic [13:0] col);
        bank_command_t b;
        b              = '0;
        b.cmd          = c;
        b.burst_length = BL_8;
        b.row_addr     = row;
        b.col_addr     = col;
        b.bank_addr    = BANK;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        done_log.delete();
    endtask

    // Presents one request until accepted; returns the accept cycle and leaves
    // the bench one cycle after the accepting edge.
    task automatic send(input op_type_t op, input logic [13:0] row, input logic [13:0] col,
                        input req_id_t id, input core_num_t core, output int t_acc);
        int budget;
        bus.req_valid          = 1'b1;
        bus.req_cmd.op_type    = op;
        bus.req_cmd.data_type  = 2'd1;
        bus.req_cmd.row_addr   = row;
        bus.req_cmd.col_addr   = col;
        bus.req_id             = id;
        bus.req_core           = core;
        t_acc  = -1;
        budget = 50;
        while (budget > 0) begin
            #1;
            if (bus.req_ready) begin
                t_acc  = cyc;
                budget = 0;
            end else begin
                budget--;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        check("request accepted", (t_acc >= 0), 1'b1);
    endtask

    task automatic chk_cmd(input string tag, input int idx, input int exp_cyc, input bank_command_t exp_c);
        check({tag, " cycle"}, cmd_log[idx].cyc, exp_cyc);
        check({tag, " beat"},  cmd_log[idx].c,   exp_c);
    endtask

    task automatic chk_done(input string tag, input int idx, input int exp_cyc,
                            input req_id_t id, input core_num_t core);
        check({tag, " cycle"}, done_log[idx].cyc,  exp_cyc);
        check({tag, " id"},    done_log[idx].id,   id);
        check({tag, " core"},  done_log[idx].core, core);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, a, a2, c, w, w2, b, p, r, n;

        rst           = 1'b1;
        close_req     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_id    = '0;
        bus.req_core  = '0;
        bus.cmd_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst req_ready", bus.req_ready, 1'b0);
        check("rst cmd_valid", bus.cmd_valid, 1'b0);
        check("rst cmd_o",     bus.cmd_o,     '0);
        rst = 1'b0;
        tick();
        check("idle closed",     closed,         1'b1);
        check("idle open_row",   open_row,       14'd0);
        check("idle done_valid", bus.done_valid, 1'b0);
        check("idle req_ready",  bus.req_ready,  1'b1);
        check("idle cmd_valid",  bus.cmd_valid,  1'b0);

        // Cold read: ACT next cycle, READ after T_RCD, done one cycle later
        clear_logs();
        send(OP_READ, 14'd5, 14'd8, 5'd3, 2'd1, t0);
        repeat (8) tick();
        check("cold cmd count", cmd_log.size(), 2);
        chk_cmd("cold ACT", 0, t0 + 1, mk(CMD_ACTIVE, 14'd5, 14'd0));
        chk_cmd("cold RD",  1, t0 + 4, mk(CMD_READ,   14'd0, 14'd8));
        check("cold done count", done_log.size(), 1);
        chk_done("cold done", 0, t0 + 5, 5'd3, 2'd1);
        check("cold open_row", open_row, 14'd5);
        check("cold not closed", closed, 1'b0);

        // Row hit twice: second READ exactly T_CCD after the first
        clear_logs();
        send(OP_READ, 14'd5, 14'd16, 5'd4, 2'd0, a);
        send(OP_READ, 14'd5, 14'd24, 5'd5, 2'd2, a2);
        repeat (8) tick();
        check("hit second accept", a2, a + 2);
        check("hit cmd count", cmd_log.size(), 2);
        chk_cmd("hit RD1", 0, a + 1, mk(CMD_READ, 14'd0, 14'd16));
        chk_cmd("hit RD2", 1, a + 5, mk(CMD_READ, 14'd0, 14'd24));
        check("hit done count", done_log.size(), 2);
        chk_done("hit done1", 0, a + 2, 5'd4, 2'd0);
        chk_done("hit done2", 1, a + 6, 5'd5, 2'd2);

        // close_req on an idle open bank: PRE, then closed
        clear_logs();
        close_req = 1'b1;
        #1;
        c = cyc;
        check("close blocks accept", bus.req_ready, 1'b0);
        tick();
        tick();
        check("close open closed", closed, 1'b1);
        close_req = 1'b0;
        check("close open cmd count", cmd_log.size(), 1);
        chk_cmd("close open PRE", 0, c + 1, mk(CMD_PRECHARGE, 14'd0, 14'd0));

        // close_req on a closed bank: nothing issued
        clear_logs();
        close_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("close idle closed", closed, 1'b1);
            tick();
        end
        close_req = 1'b0;
        check("close idle no cmd", cmd_log.size(), 0);

        // WRITE row5 then READ row9: PRE waits for both tRAS and tWR
        clear_logs();
        send(OP_WRITE, 14'd5, 14'd2, 5'd7, 2'd2, w);
        send(OP_READ,  14'd9, 14'd3, 5'd8, 2'd3, w2);
        repeat (14) tick();
        check("miss second accept", w2, w + 5);
        check("miss cmd count", cmd_log.size(), 5);
        chk_cmd("miss ACT5", 0, w + 1,  mk(CMD_ACTIVE,    14'd5, 14'd0));
        chk_cmd("miss WR",   1, w + 4,  mk(CMD_WRITE,     14'd0, 14'd2));
        chk_cmd("miss PRE",  2, w + 9,  mk(CMD_PRECHARGE, 14'd0, 14'd0));
        chk_cmd("miss ACT9", 3, w + 12, mk(CMD_ACTIVE,    14'd9, 14'd0));
        chk_cmd("miss RD",   4, w + 15, mk(CMD_READ,      14'd0, 14'd3));
        check("miss done count", done_log.size(), 2);
        chk_done("miss done WR", 0, w + 5,  5'd7, 2'd2);
        chk_done("miss done RD", 1, w + 16, 5'd8, 2'd3);
        check("miss open_row", open_row, 14'd9);

        // Backpressure in ISSUE_RW: beat held stable, nothing completes
        clear_logs();
        bus.cmd_ready = 1'b0;
        send(OP_READ, 14'd9, 14'd5, 5'd9, 2'd1, b);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp cmd_valid",  bus.cmd_valid,  1'b1);
            check("bp cmd_o",      bus.cmd_o,      mk(CMD_READ, 14'd0, 14'd5));
            check("bp req_ready",  bus.req_ready,  1'b0);
            check("bp done_valid", bus.done_valid, 1'b0);
            tick();
        end
        bus.cmd_ready = 1'b1;
        repeat (3) tick();
        check("bp cmd count", cmd_log.size(), 1);
        chk_cmd("bp RD", 0, b + 6, mk(CMD_READ, 14'd0, 14'd5));
        check("bp done count", done_log.size(), 1);
        chk_done("bp done", 0, b + 7, 5'd9, 2'd1);

        // close_req with a pending hit: the READ goes first, then PRE
        clear_logs();
        send(OP_READ, 14'd9, 14'd6, 5'd10, 2'd0, p);
        close_req = 1'b1;
        #1;
        check("close pending not closed", closed, 1'b0);
        repeat (3) tick();
        check("close pending closed", closed, 1'b1);
        close_req = 1'b0;
        check("close pending cmd count", cmd_log.size(), 2);
        chk_cmd("close pending RD",  0, p + 1, mk(CMD_READ,      14'd0, 14'd6));
        chk_cmd("close pending PRE", 1, p + 3, mk(CMD_PRECHARGE, 14'd0, 14'd0));
        check("close pending done count", done_log.size(), 1);
        chk_done("close pending done", 0, p + 2, 5'd10, 2'd0);

        // Reset while a READ is waiting in ISSUE_RW drops it
        repeat (3) tick();
        clear_logs();
        send(OP_READ, 14'd3, 14'd1, 5'd11, 2'd1, r);
        tick();
        bus.cmd_ready = 1'b0;
        repeat (2) tick();
        check("rstrw waiting", bus.cmd_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rstrw in rst cmd_valid", bus.cmd_valid, 1'b0);
        check("rstrw in rst req_ready", bus.req_ready, 1'b0);
        tick();
        rst           = 1'b0;
        bus.cmd_ready = 1'b1;
        #1;
        check("rstrw cmd_valid",  bus.cmd_valid,  1'b0);
        check("rstrw closed",     closed,         1'b1);
        check("rstrw open_row",   open_row,       14'd0);
        check("rstrw done_valid", bus.done_valid, 1'b0);
        repeat (5) tick();
        check("rstrw cmd count", cmd_log.size(), 1);
        chk_cmd("rstrw ACT", 0, r + 1, mk(CMD_ACTIVE, 14'd3, 14'd0));
        check("rstrw no done", done_log.size(), 0);

        // After reset the same row must be re-activated
        clear_logs();
        send(OP_READ, 14'd3, 14'd1, 5'd12, 2'd1, n);
        repeat (6) tick();
        check("post rst cmd count", cmd_log.size(), 2);
        chk_cmd("post rst ACT", 0, n + 1, mk(CMD_ACTIVE, 14'd3, 14'd0));
        chk_cmd("post rst RD",  1, n + 4, mk(CMD_READ,   14'd0, 14'd1));
        check("post rst done count", done_log.size(), 1);
        chk_done("post rst done", 0, n + 5, 5'd12, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
